// File: rtl/sqacc_pkg.sv
// Shared types, default parameters and helpers for the sqacc_seq
// square-accumulate engine.
package sqacc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ITERS_DEF = 10;
  localparam int WIDTH_DEF = 32;
  localparam int HIST_DEF  = 10;
  // Widest history the parity helper accepts; narrower histories are zero-extended.
  localparam int HIST_MAX  = 64;

  function automatic logic hist_parity(input logic [HIST_MAX-1:0] hist, input logic cond);
    return (^hist) ^ cond;
  endfunction

endpackage

// File: rtl/sqacc_seq_if.sv
// Request/result handshake bundle for sqacc_seq; the requester uses the
// master modport and the engine uses the slave modport.
interface sqacc_seq_if
  import sqacc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic             inCond;
  logic [WIDTH-1:0] inComp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             o_end;

  modport master (
    output in_valid, inCond, inComp, out_ready,
    input  in_ready, out_valid, out1, out2, o_end
  );

  modport slave (
    input  in_valid, inCond, inComp, out_ready,
    output in_ready, out_valid, out1, out2, o_end
  );

endinterface

// File: rtl/sqacc_step.sv
// One square-accumulate iteration: ((v + x)^2) mod 2^WIDTH, purely combinational.
module sqacc_step
  import sqacc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_v,
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_n
);

  logic [WIDTH-1:0] w_sum;

  assign w_sum = i_v + i_x;
  // Self-determined WIDTH context keeps only the low WIDTH bits of the product.
  assign o_n   = w_sum * w_sum;

endmodule

// File: rtl/sqacc_seq.sv
// Handshaked, iterative square-accumulate engine: ITERS rounds of
// v = (v + x)^2 per accepted request, gated by a condition-history register.
module sqacc_seq
  import sqacc_pkg::*;
#(
  parameter int ITERS = ITERS_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int HIST  = HIST_DEF
) (
  input logic        clk,
  input logic        rst_n,
  sqacc_seq_if.slave bus
);

  localparam int             CW   = $clog2(ITERS + 1);
  localparam logic [CW-1:0]  LAST = CW'(ITERS - 1);

  state_t           r_state, w_state_nxt;
  logic [HIST-1:0]  r_hist,  w_hist_nxt;
  logic [WIDTH-1:0] r_x,     w_x_nxt;
  logic [WIDTH-1:0] r_v,     w_v_nxt;
  logic [WIDTH-1:0] r_chk,   w_chk_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_out1,  w_out1_nxt;
  logic [WIDTH-1:0] r_out2,  w_out2_nxt;
  logic             r_end,   w_end_nxt;

  logic             w_gate;
  logic             w_par;
  logic [WIDTH-1:0] w_n;

  assign w_gate = r_hist[HIST-1] | bus.inCond;
  assign w_par  = hist_parity(HIST_MAX'(r_hist), bus.inCond);

  sqacc_step #(.WIDTH(WIDTH)) u_step (
    .i_v (r_v),
    .i_x (r_x),
    .o_n (w_n)
  );

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_x_nxt     = r_x;
    w_v_nxt     = r_v;
    w_chk_nxt   = r_chk;
    w_cnt_nxt   = r_cnt;
    w_out1_nxt  = r_out1;
    w_out2_nxt  = r_out2;
    w_end_nxt   = r_end;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_x_nxt    = bus.inComp;
          w_end_nxt  = w_gate;
          w_hist_nxt = {r_hist[HIST-2:0], w_par};
          w_v_nxt    = {WIDTH{1'b0}};
          w_chk_nxt  = {WIDTH{1'b0}};
          w_cnt_nxt  = {CW{1'b0}};
          if (w_gate) begin
            w_state_nxt = RUN;
          end else begin
            w_out1_nxt  = {WIDTH{1'b0}};
            w_out2_nxt  = {WIDTH{1'b0}};
            w_state_nxt = DONE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_v_nxt   = w_n;
        w_chk_nxt = r_chk ^ w_n;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          w_out1_nxt  = w_n;
          w_out2_nxt  = r_chk ^ w_n;
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= {HIST{1'b0}};
      r_x    <= {WIDTH{1'b0}};
      r_v    <= {WIDTH{1'b0}};
      r_chk  <= {WIDTH{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_out1 <= {WIDTH{1'b0}};
      r_out2 <= {WIDTH{1'b0}};
      r_end  <= 1'b0;
    end else begin
      r_hist <= w_hist_nxt;
      r_x    <= w_x_nxt;
      r_v    <= w_v_nxt;
      r_chk  <= w_chk_nxt;
      r_cnt  <= w_cnt_nxt;
      r_out1 <= w_out1_nxt;
      r_out2 <= w_out2_nxt;
      r_end  <= w_end_nxt;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out1      = r_out1;
  assign bus.out2      = r_out2;
  assign bus.o_end     = r_end;

endmodule

// File: tb/tb_sqacc_seq.sv
// Bench for sqacc_seq: four instances (ITERS = 10, 3, 2, 1) share one stimulus
// stream and are compared against a queue-based reference model.
module tb_sqacc_seq;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_cond = 1'b0;
  logic [31:0] in_comp = 32'd0;
  logic        out_ready = 1'b0;

  wire [NDUT-1:0]       in_ready_a;
  wire [NDUT-1:0]       out_valid_a;
  wire [NDUT-1:0]       o_end_a;
  wire [NDUT-1:0][31:0] out1_a;
  wire [NDUT-1:0][31:0] out2_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int iters_of(input int i);
    return (i == 0) ? 10 : (i == 1) ? 3 : (i == 2) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int IT = (g == 0) ? 10 : (g == 1) ? 3 : (g == 2) ? 2 : 1;
    sqacc_seq_if #(.WIDTH(32)) ifc ();
    assign ifc.in_valid  = in_valid;
    assign ifc.inCond    = in_cond;
    assign ifc.inComp    = in_comp;
    assign ifc.out_ready = out_ready;
    sqacc_seq #(.ITERS(IT), .WIDTH(32), .HIST(10)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
    );
    assign in_ready_a[g]  = ifc.in_ready;
    assign out_valid_a[g] = ifc.out_valid;
    assign o_end_a[g]     = ifc.o_end;
    assign out1_a[g]      = ifc.out1;
    assign out2_a[g]      = ifc.out2;
  end

  // Reference model: last 10 parity bits, oldest first.
  bit hq[$];

  logic [31:0] res1 [NDUT];
  logic [31:0] res2 [NDUT];
  logic        resend [NDUT];
  int          lat [NDUT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_accept(input logic cond, output logic gate);
    bit p;
    p = cond;
    foreach (hq[k]) p ^= hq[k];
    gate = ((hq.size() == 10) ? hq[0] : 1'b0) | cond;
    hq.push_back(p);
    if (hq.size() > 10) void'(hq.pop_front());
  endfunction

  function automatic void model_run(input int it, input logic gate, input logic [31:0] x,
                                    output logic [31:0] o1, output logic [31:0] o2);
    bit [63:0] v, c, s;
    v = 64'd0;
    c = 64'd0;
    if (gate) begin
      for (int k = 0; k < it; k++) begin
        s = (v + {32'd0, x}) & 64'hFFFF_FFFF;
        v = (s * s) & 64'hFFFF_FFFF;
        c = c ^ v;
      end
    end
    o1 = v[31:0];
    o2 = c[31:0];
  endfunction

  task automatic check_idle_zero(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s in_ready d%0d", tag, i), 32'(in_ready_a[i]), 32'd1);
      check($sformatf("%s out_valid d%0d", tag, i), 32'(out_valid_a[i]), 32'd0);
      check($sformatf("%s out1 d%0d", tag, i), out1_a[i], 32'd0);
      check($sformatf("%s out2 d%0d", tag, i), out2_a[i], 32'd0);
      check($sformatf("%s o_end d%0d", tag, i), 32'(o_end_a[i]), 32'd0);
    end
  endtask

  // One request through all instances; stall > 0 holds out_ready low that many cycles.
  task automatic run_txn(input logic cond, input logic [31:0] comp, input int stall);
    logic        gate;
    logic [31:0] e1 [NDUT];
    logic [31:0] e2 [NDUT];
    bit          done [NDUT];
    int          edges;
    int          ndone;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("pre in_ready d%0d", i), 32'(in_ready_a[i]), 32'd1);
    end
    model_accept(cond, gate);
    for (int i = 0; i < NDUT; i++) begin
      model_run(iters_of(i), gate, comp, e1[i], e2[i]);
      done[i] = 1'b0;
    end
    in_valid  = 1'b1;
    in_cond   = cond;
    in_comp   = comp;
    out_ready = (stall == 0);
    edges = 0;
    ndone = 0;
    while (ndone < NDUT && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < NDUT; i++) begin
        if (!done[i] && out_valid_a[i]) begin
          done[i]   = 1'b1;
          ndone++;
          lat[i]    = edges;
          res1[i]   = out1_a[i];
          res2[i]   = out2_a[i];
          resend[i] = o_end_a[i];
          check($sformatf("out1 d%0d x=%0h", i, comp), out1_a[i], e1[i]);
          check($sformatf("out2 d%0d x=%0h", i, comp), out2_a[i], e2[i]);
          check($sformatf("o_end d%0d", i), 32'(o_end_a[i]), 32'(gate));
          check($sformatf("latency d%0d", i), 32'(edges), gate ? 32'(iters_of(i) + 1) : 32'd1);
        end
      end
    end
    if (ndone < NDUT) begin
      errors++;
      $display("FAIL timeout: %0d of %0d results after %0d cycles", ndone, NDUT, edges);
    end
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_cond  = 1'($urandom_range(0, 1));
      in_comp  = $urandom;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("stall out_valid d%0d", i), 32'(out_valid_a[i]), 32'd1);
        check($sformatf("stall in_ready d%0d", i), 32'(in_ready_a[i]), 32'd0);
        check($sformatf("stall out1 d%0d", i), out1_a[i], e1[i]);
        check($sformatf("stall out2 d%0d", i), out2_a[i], e2[i]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("post out_valid d%0d", i), 32'(out_valid_a[i]), 32'd0);
      check($sformatf("post in_ready d%0d", i), 32'(in_ready_a[i]), 32'd1);
      check($sformatf("post hold out1 d%0d", i), out1_a[i], e1[i]);
    end
  endtask

  typedef struct {
    logic        cond;
    logic [31:0] comp;
    int          dut;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eend;
    int          elat;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        g;
    logic        c;
    logic [31:0] x;
    int          st;

    tbl[0] = '{1'b0, 32'd5,          1, 32'd0,  32'd0,  1'b0, 1};
    tbl[1] = '{1'b1, 32'd1,          1, 32'd25, 32'd28, 1'b1, 4};
    tbl[2] = '{1'b1, 32'd2,          2, 32'd36, 32'd32, 1'b1, 3};
    tbl[3] = '{1'b1, 32'hFFFF_FFFF,  3, 32'd1,  32'd1,  1'b1, 2};

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("after_reset");

    for (int t = 0; t < 4; t++) begin
      run_txn(tbl[t].cond, tbl[t].comp, 0);
      check($sformatf("tbl%0d out1", t), res1[tbl[t].dut], tbl[t].e1);
      check($sformatf("tbl%0d out2", t), res2[tbl[t].dut], tbl[t].e2);
      check($sformatf("tbl%0d o_end", t), 32'(resend[tbl[t].dut]), 32'(tbl[t].eend));
      check($sformatf("tbl%0d latency", t), 32'(lat[tbl[t].dut]), 32'(tbl[t].elat));
    end

    // Back-pressure: result held five cycles while in_valid toggles.
    run_txn(1'b1, 32'd3, 5);

    for (int t = 0; t < 40; t++) begin
      c  = 1'($urandom_range(0, 1));
      x  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_txn(c, x, st);
    end

    // Reset in the fourth RUN cycle of the ITERS=10 instance.
    in_valid = 1'b1;
    in_cond  = 1'b1;
    in_comp  = 32'd7;
    model_accept(1'b1, g);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_run out_valid d0", 32'(out_valid_a[0]), 32'd0);
    check("mid_run in_ready d0", 32'(in_ready_a[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    hq.delete();
    @(negedge clk);
    check_idle_zero("reset_release");
    run_txn(1'b0, 32'd5, 0);
    check("post_reset gate0 latency", 32'(lat[0]), 32'd1);
    check("post_reset gate0 out1", res1[0], 32'd0);
    check("post_reset gate0 o_end", 32'(resend[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
